// File: rtl/apb_pkg.sv
// Shared definitions for the APB master bridge: FSM state encoding and default widths.
package apb_pkg;

  localparam int APB_ADDR_W  = 32;
  localparam int APB_DATA_W  = 32;
  localparam int APB_TIMEOUT = 16;
  localparam int APB_CNT_W   = 8;

  // One-hot-ish 3-bit encoding leaves spare codes so a corrupted state is detectable.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_SETUP  = 3'b001,
    ST_ACCESS = 3'b010,
    ST_RESP   = 3'b100
  } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired flags that one more stalled cycle reaches TIMEOUT.
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic pclk,
  input  logic preset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [APB_CNT_W-1:0] LAST = APB_CNT_W'(TIMEOUT - 1);

  logic [APB_CNT_W-1:0] count;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB requester bridge with registered outputs
// and an ACCESS-phase timeout.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = APB_TIMEOUT
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state, state_nxt;
  logic              cmd_ready_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt;
  logic              rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              cnt_clr, cnt_en, tmo_expired;

  apb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .pclk    (pclk),
    .preset  (preset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (tmo_expired)
  );

  always_comb begin
    state_nxt       = state;
    cmd_ready_nxt   = 1'b0;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    cnt_clr         = 1'b0;
    cnt_en          = 1'b0;

    case (state)
      ST_IDLE: begin
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        cmd_ready_nxt = 1'b1;
        // cmd_ready is the registered copy, so the first IDLE cycle after reset cannot accept.
        if (cmd_valid && cmd_ready) begin
          state_nxt     = ST_SETUP;
          cmd_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          pwrite_nxt    = cmd_write;
          paddr_nxt     = cmd_addr;
          pwdata_nxt    = cmd_wdata;
        end
      end

      ST_SETUP: begin
        state_nxt   = ST_ACCESS;
        penable_nxt = 1'b1;
        cnt_clr     = 1'b1;
      end

      ST_ACCESS: begin
        // A completing pready wins over a timeout reached on the same cycle.
        if (pready) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = pslverr;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = (!pwrite && !pslverr) ? prdata : '0;
        end else if (tmo_expired) begin
          state_nxt       = ST_RESP;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt     = ST_IDLE;
          rsp_valid_nxt = 1'b0;
          cmd_ready_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt     = ST_IDLE;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
        rsp_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready   <= cmd_ready_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning APB/command address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning APB/command data width.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning max ACCESS cycles waiting for pready (legal range 2..255).
REQ-004 SHALL have port: pclk  in  1  the single clock, rising edge.
REQ-005 SHALL have port: preset  in  1  reset, asynchronous and active-high.
REQ-006 SHALL have port: cmd_valid  in  1  command request.
REQ-007 SHALL have port: cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high at a clock edge.
REQ-008 SHALL have port: cmd_write  in  1  1=write, 0=read.
REQ-009 SHALL have port: cmd_addr  in  ADDR_W  target address.
REQ-010 SHALL have port: cmd_wdata  in  DATA_W  write data.
REQ-011 SHALL have port: rsp_valid  out  1  response available.
REQ-012 SHALL have port: rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
REQ-013 SHALL have port: rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
REQ-014 SHALL have port: rsp_err  out  1  slave error or timeout.
REQ-015 SHALL have port: rsp_timeout  out  1  transfer aborted on timeout.
REQ-016 SHALL have ports: psel, penable, pwrite  out  1 each; paddr  out  ADDR_W; pwdata  out  DATA_W  APB requester signals.
REQ-017 SHALL have ports: prdata  in  DATA_W; pready, pslverr  in  1 each  APB completer signals.

Function
REQ-018 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE; every output SHALL be registered.
REQ-019 IDLE: cmd_ready=1, psel=0, penable=0; on accept, latch cmd_write/cmd_addr/cmd_wdata and enter SETUP.
REQ-020 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP (one outstanding transfer only).
REQ-021 SETUP: exactly one cycle with psel=1, penable=0, and paddr/pwrite/pwdata driven from latched values.
REQ-022 ACCESS: psel=1 and penable=1; paddr/pwrite/pwdata SHALL stay unchanged until the transfer ends.
REQ-023 In ACCESS with pready=1: capture pslverr into rsp_err, capture prdata into rsp_rdata (reads without error only, else 0), and drop psel/penable on the next edge.
REQ-024 pready and pslverr SHALL be ignored outside ACCESS.
REQ-025 Timeout counter SHALL clear on entering ACCESS and increment on each ACCESS cycle without pready; on reaching TIMEOUT: abort, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-026 RESP: rsp_valid=1 with rsp_rdata/rsp_err/rsp_timeout held stable until rsp_ready=1; then rsp_valid=0 and the FSM returns to IDLE.
REQ-027 Latency: accept at edge T gives psel at T+1 and penable at T+2; pready sampled at edge T+k gives rsp_valid from T+k.
REQ-028 rsp_ready held high in RESP SHALL complete the response in one cycle; a new command SHALL be accepted no earlier than the following IDLE cycle.
REQ-029 Illegal FSM encodings SHALL return to IDLE with psel=0.

Reset
REQ-030 preset=1 SHALL immediately force IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, timeout count=0, and cmd_ready=0 while asserted.
REQ-031 Reset mid-transfer SHALL abandon the transfer without producing any response; cmd_ready SHALL be 1 on the first edge after release.

Structure
REQ-032 Shared package apb_pkg SHALL hold the FSM state enum and the default ADDR_W/DATA_W/TIMEOUT constants.
REQ-033 The timeout counter SHALL be one sub-module, apb_timeout_cnt (clear, enable, expired outputs).

Verification
REQ-034 Write of 0xDEADBEEF to 0x5 on a zero-wait-state completer: SETUP 1 cycle, ACCESS 1 cycle, then rsp_valid=1, rsp_err=0, rsp_rdata=0.
REQ-035 Read of 0x5 after REQ-034: rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 Read of 0x40 with completer returning pslverr=1 and pready=1: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-037 Completer holds pready=0 with TIMEOUT=16: abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; psel drops.
REQ-038 rsp_ready held 0 for 5 cycles: rsp_valid and all rsp_* values stay stable and cmd_ready=0; a second command is accepted only after the handshake.
REQ-039 preset pulsed during ACCESS: psel/penable drop with no clock edge required, no response is produced, and the next command completes normally.
